ofdm_tx_sched: RTL and testbench
================================

Name: ofdm_tx_sched

Overview:
- Symbol-level scheduler for the OFDM transmit chain. Sequences each frame as N_PREAMBLE preamble symbols followed by N_DATA data symbols.
- Drives the per-symbol valid/start-of-symbol strobes into the IFFT / cyclic-prefix-insertion path. Each burst is exactly FFTSIZE samples, followed by a CPSIZE-cycle idle gap so the CP stage can emit FFTSIZE+CPSIZE output samples per symbol.
- Fetches preamble samples by address and data samples by read strobe from the upstream symbol buffer.

Parameters:
- FFTSIZE, 1024, samples per OFDM symbol (power of 2, >=8).
- CPSIZE, 32, cyclic-prefix length; idle cycles after each burst (1..FFTSIZE-1).
- N_PREAMBLE, 2, preamble symbols per frame (1..15).
- N_DATA, 14, data symbols per frame (1..255).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a frame; sampled only in IDLE.
- cont  in  1  continuous mode; sampled at frame end.
- data_avail  in  1  upstream buffer holds at least one complete data symbol.
- sym_ival  out  1  sample valid to IFFT/CP path.
- sym_isop  out  1  first sample of a symbol; coincides with the first sym_ival.
- sym_type  out  2  0=idle, 1=preamble, 2=data; valid while sym_ival=1.
- pre_addr  out  $clog2(FFTSIZE)  preamble ROM sample address.
- pre_sym  out  4  preamble symbol index within the frame.
- data_rd  out  1  pop one sample from the upstream data buffer.
- sym_idx  out  8  data symbol index within the frame.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse at frame end.
- underflow  out  1  sticky: a data symbol was not ready on time.

Behaviour:
- Output timing: all outputs are registered. Reset value of every output is 0.
- Reset mid-frame: the FSM returns to IDLE and all outputs are 0 on the following cycle. The underflow flag is cleared.
- States: IDLE, PRE, PGAP, DWAIT, DATA, DGAP.
- Counters:
  - smp_cnt, $clog2(FFTSIZE) bits: counts 0..FFTSIZE-1 in burst states; reused as 0..CPSIZE-1 in gap states.
  - pre_cnt and dat_cnt: symbol counters.
- IDLE:
  - busy=0.
  - start=1 -> PRE with smp_cnt=0 and pre_cnt=0. The first sym_ival appears on the cycle after start is sampled (latency 1).
  - underflow is cleared on accepted start.
- PRE:
  - sym_ival=1, sym_type=1, pre_addr=smp_cnt, pre_sym=pre_cnt.
  - sym_isop=1 only when smp_cnt=0.
  - After the FFTSIZE-th sample -> PGAP.
- PGAP:
  - CPSIZE cycles with sym_ival=0.
  - On the last gap cycle: if pre_cnt<N_PREAMBLE-1, increment pre_cnt and go to PRE. Otherwise go to DATA if data_avail=1, else DWAIT.
- DWAIT:
  - sym_ival=0.
  - underflow is set on entry and held until the next accepted start or reset.
  - Go to DATA on the cycle after data_avail=1.
- DATA:
  - sym_ival=1, data_rd=1, sym_type=2, sym_idx=dat_cnt.
  - sym_isop on the first sample.
  - Exactly FFTSIZE data_rd pulses per symbol. data_avail is ignored mid-burst; a started burst never stalls.
  - After the FFTSIZE-th sample -> DGAP.
- DGAP:
  - CPSIZE idle cycles.
  - On the last gap cycle: if dat_cnt<N_DATA-1, increment dat_cnt and go to DATA if data_avail=1, else DWAIT.
  - Otherwise the frame ends. frame_done=1 for one cycle on the cycle after the last gap cycle.
  - At frame end, if cont=1 go directly to PRE with counters cleared; busy stays 1 and there is no idle cycle. If cont=0 go to IDLE.
- busy:
  - Equals 1 in every state except IDLE.
  - When the frame ends to IDLE, busy falls in the same cycle frame_done pulses.
  - In cont=1 mode, busy stays high through the frame boundary.
- start:
  - Ignored while busy=1.
  - start held high in IDLE is treated as a single request.
  - start and rst in the same cycle: rst wins.
- Symbol period: every symbol occupies exactly FFTSIZE+CPSIZE cycles when there is no underflow.
- Frame length: (N_PREAMBLE+N_DATA)*(FFTSIZE+CPSIZE) cycles plus any DWAIT cycles.
- Counter wrap: smp_cnt wraps to 0 at each state change and never overflows. sym_idx and pre_sym saturate at their parameter limits.

Test Plan:
All scenarios use FFTSIZE=16, CPSIZE=4, N_PREAMBLE=1, N_DATA=2.
- Basic frame:
  - Stimulus: data_avail=1 constantly; start pulse sampled at cycle 0.
  - Required response: sym_ival high on cycles 1-16 (type 1, pre_addr 0..15), 21-36 (type 2) and 41-56 (type 2). sym_isop high at cycles 1, 21 and 41. data_rd count is 32. frame_done pulses at cycle 61; busy is 1 on cycles 1-60 and 0 from cycle 61.
- Underflow:
  - Stimulus: as the basic frame, but data_avail=0 on cycles 0-24, then 1.
  - Required response: DWAIT from cycle 21; underflow=1 from cycle 21. The first data burst starts at cycle 26 with isop, and is exactly 16 samples long. underflow stays 1 after frame_done.
- Continuous mode:
  - Stimulus: cont=1 and data_avail=1.
  - Required response: the second frame's preamble isop occurs at cycle 61. busy never drops.
- Mid-frame events:
  - Stimulus: rst asserted at cycle 30 (during the DATA burst).
  - Required response: all outputs are 0 at cycle 31. A new start sampled at cycle 40 gives isop at cycle 41 with sym_type=1.
- start while busy:
  - Stimulus: start pulses at cycles 10 and 50 while busy=1.
  - Required response: no effect; the timeline is identical to the basic frame.

Source files
------------

// File: rtl/ofdm_tx_sched.sv
// ofdm_tx_sched: symbol-level scheduler for the OFDM transmit chain.
// Latency: first sym_ival one cycle after an accepted start; every output is registered.
// Backpressure: none mid-burst; a data symbol starts only when data_avail is seen, else DWAIT.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, cont         frame request (IDLE only), continuous mode (sampled at frame end)
//   data_avail          upstream buffer holds at least one full data symbol
//   sym_ival, sym_isop  sample valid / first sample of symbol to the IFFT/CP path
//   sym_type            0 idle, 1 preamble, 2 data
//   pre_addr, pre_sym   preamble ROM sample address and preamble symbol index
//   data_rd, sym_idx    data buffer pop strobe and data symbol index
//   busy, frame_done    frame in progress, one-cycle end-of-frame pulse
//   underflow           sticky: a data symbol was late
module ofdm_tx_sched #(
  parameter int FFTSIZE    = 1024,
  parameter int CPSIZE     = 32,
  parameter int N_PREAMBLE = 2,
  parameter int N_DATA     = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       cont,
  input  logic                       data_avail,
  output logic                       sym_ival,
  output logic                       sym_isop,
  output logic [1:0]                 sym_type,
  output logic [$clog2(FFTSIZE)-1:0] pre_addr,
  output logic [3:0]                 pre_sym,
  output logic                       data_rd,
  output logic [7:0]                 sym_idx,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       underflow
);

  localparam int AW = $clog2(FFTSIZE);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_PGAP  = 3'd2;
  localparam logic [2:0] S_DWAIT = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_DGAP  = 3'd5;

  localparam logic [1:0] TYPE_IDLE = 2'd0;
  localparam logic [1:0] TYPE_PRE  = 2'd1;
  localparam logic [1:0] TYPE_DATA = 2'd2;

  localparam logic [AW-1:0] FFT_LAST = AW'(FFTSIZE - 1);
  localparam logic [AW-1:0] CP_LAST  = AW'(CPSIZE - 1);
  localparam logic [AW-1:0] SMP_ONE  = AW'(1);
  localparam logic [3:0]    PRE_LAST = 4'(N_PREAMBLE - 1);
  localparam logic [7:0]    DAT_LAST = 8'(N_DATA - 1);

  logic [2:0]    state, state_nxt;
  logic [AW-1:0] smp_cnt, smp_nxt;
  logic [3:0]    pre_cnt, pre_nxt;
  logic [7:0]    dat_cnt, dat_nxt;
  logic          start_armed;
  logic          accept;
  logic          frame_end;
  logic          frame_end_q;

  // Next-state logic. smp_cnt counts samples in burst states and gap cycles
  // in gap states; it is cleared on every state change so it never wraps on
  // its own. Symbol counters only ever count up to their last index, so the
  // exported indices cannot exceed the parameter limits.
  always_comb begin
    state_nxt = state;
    smp_nxt   = smp_cnt;
    pre_nxt   = pre_cnt;
    dat_nxt   = dat_cnt;
    frame_end = 1'b0;
    accept    = (state == S_IDLE) && start && start_armed;

    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_PRE;
          smp_nxt   = '0;
          pre_nxt   = '0;
          dat_nxt   = '0;
        end
      end

      S_PRE: begin
        if (smp_cnt == FFT_LAST) begin
          state_nxt = S_PGAP;
          smp_nxt   = '0;
        end else begin
          smp_nxt = smp_cnt + SMP_ONE;
        end
      end

      S_PGAP: begin
        if (smp_cnt == CP_LAST) begin
          smp_nxt = '0;
          if (pre_cnt != PRE_LAST) begin
            pre_nxt   = pre_cnt + 4'd1;
            state_nxt = S_PRE;
          end else begin
            state_nxt = data_avail ? S_DATA : S_DWAIT;
          end
        end else begin
          smp_nxt = smp_cnt + SMP_ONE;
        end
      end

      S_DWAIT: begin
        smp_nxt = '0;
        if (data_avail) begin
          state_nxt = S_DATA;
        end
      end

      S_DATA: begin
        // data_avail is deliberately not looked at here: a burst never stalls.
        if (smp_cnt == FFT_LAST) begin
          state_nxt = S_DGAP;
          smp_nxt   = '0;
        end else begin
          smp_nxt = smp_cnt + SMP_ONE;
        end
      end

      S_DGAP: begin
        if (smp_cnt == CP_LAST) begin
          smp_nxt = '0;
          if (dat_cnt != DAT_LAST) begin
            dat_nxt   = dat_cnt + 8'd1;
            state_nxt = data_avail ? S_DATA : S_DWAIT;
          end else begin
            // Frame end: continuous mode restarts the preamble with no idle cycle.
            frame_end = 1'b1;
            pre_nxt   = '0;
            dat_nxt   = '0;
            state_nxt = cont ? S_PRE : S_IDLE;
          end
        end else begin
          smp_nxt = smp_cnt + SMP_ONE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
        smp_nxt   = '0;
        pre_nxt   = '0;
        dat_nxt   = '0;
      end
    endcase
  end

  // State registers plus the registered output decode. Outputs are decoded
  // from the current state, so they trail the state register by one cycle;
  // this gives the one-cycle start-to-first-sample latency. frame_end goes
  // through frame_end_q so frame_done lines up with the falling busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      smp_cnt     <= '0;
      pre_cnt     <= '0;
      dat_cnt     <= '0;
      start_armed <= 1'b1;
      frame_end_q <= 1'b0;
      sym_ival    <= 1'b0;
      sym_isop    <= 1'b0;
      sym_type    <= TYPE_IDLE;
      pre_addr    <= '0;
      pre_sym     <= '0;
      data_rd     <= 1'b0;
      sym_idx     <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      state       <= state_nxt;
      smp_cnt     <= smp_nxt;
      pre_cnt     <= pre_nxt;
      dat_cnt     <= dat_nxt;
      frame_end_q <= frame_end;

      // A start held high counts once: it must drop before it can re-arm.
      if (!start) begin
        start_armed <= 1'b1;
      end else if (accept) begin
        start_armed <= 1'b0;
      end

      sym_ival   <= (state == S_PRE) || (state == S_DATA);
      sym_isop   <= ((state == S_PRE) || (state == S_DATA)) && (smp_cnt == '0);
      sym_type   <= (state == S_PRE)  ? TYPE_PRE  :
                    (state == S_DATA) ? TYPE_DATA : TYPE_IDLE;
      pre_addr   <= (state == S_PRE)  ? smp_cnt : '0;
      pre_sym    <= (state == S_PRE)  ? pre_cnt : '0;
      data_rd    <= (state == S_DATA);
      sym_idx    <= (state == S_DATA) ? dat_cnt : '0;
      busy       <= (state != S_IDLE);
      frame_done <= frame_end_q;

      // Sticky until the next accepted start (or reset).
      if (accept) begin
        underflow <= 1'b0;
      end else if (state == S_DWAIT) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ofdm_tx_sched.sv
// tb_ofdm_tx_sched: scenario bench for ofdm_tx_sched (FFTSIZE=16, CPSIZE=4, N_PREAMBLE=1, N_DATA=2).
// Latency: expected outputs for cycle c are queued as cycle c stimulus is driven, popped after edge c.
// Backpressure: n/a; data_avail is driven from per-scenario stimulus.
module tb_ofdm_tx_sched;

  logic       clk;
  logic       rst;
  logic       start;
  logic       cont;
  logic       data_avail;
  logic       sym_ival;
  logic       sym_isop;
  logic [1:0] sym_type;
  logic [3:0] pre_addr;
  logic [3:0] pre_sym;
  logic       data_rd;
  logic [7:0] sym_idx;
  logic       busy;
  logic       frame_done;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       ival;
    logic       isop;
    logic [1:0] typ;
    logic [3:0] addr;
    logic [3:0] psym;
    logic       rd;
    logic [7:0] sidx;
    logic       busy;
    logic       done;
    logic       uf;
  } exp_t;

  exp_t sb[$];

  ofdm_tx_sched #(
    .FFTSIZE   (16),
    .CPSIZE    (4),
    .N_PREAMBLE(1),
    .N_DATA    (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cont      (cont),
    .data_avail(data_avail),
    .sym_ival  (sym_ival),
    .sym_isop  (sym_isop),
    .sym_type  (sym_type),
    .pre_addr  (pre_addr),
    .pre_sym   (pre_sym),
    .data_rd   (data_rd),
    .sym_idx   (sym_idx),
    .busy      (busy),
    .frame_done(frame_done),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference timeline of one frame whose start is sampled at cycle s, with
  // d extra wait cycles before the first data symbol. Symbol period is 20.
  function automatic exp_t frame_model(int c, int s, int d);
    exp_t e;
    int r;
    e = '0;
    r = c - s;
    if (r >= 1 && r <= 16) begin
      e.ival = 1'b1;
      e.typ  = 2'd1;
      e.isop = (r == 1);
      e.addr = 4'(r - 1);
    end
    for (int k = 0; k < 2; k++) begin
      if (r >= 21 + d + 20 * k && r < 37 + d + 20 * k) begin
        e.ival = 1'b1;
        e.typ  = 2'd2;
        e.rd   = 1'b1;
        e.isop = (r == 21 + d + 20 * k);
        e.sidx = 8'(k);
      end
    end
    e.busy = (r >= 1 && r <= 60 + d);
    e.done = (r == 61 + d);
    e.uf   = (d > 0 && r >= 21);
    return e;
  endfunction

  // Index fields are only meaningful while the matching symbol type is valid.
  function automatic exp_t observe(exp_t e);
    exp_t o;
    o.ival = sym_ival;
    o.isop = sym_isop;
    o.typ  = sym_type;
    o.addr = (e.ival && e.typ == 2'd1) ? pre_addr : 4'd0;
    o.psym = (e.ival && e.typ == 2'd1) ? pre_sym  : 4'd0;
    o.rd   = data_rd;
    o.sidx = (e.ival && e.typ == 2'd2) ? sym_idx  : 8'd0;
    o.busy = busy;
    o.done = frame_done;
    o.uf   = underflow;
    return o;
  endfunction

  task automatic apply_reset();
    rst        = 1'b1;
    start      = 1'b0;
    cont       = 1'b0;
    data_avail = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    exp_t e;
    exp_t o;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      sb.push_back('0);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      o = observe(e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", c, o, e);
      end
      checks++;
      if ({pre_addr, pre_sym, sym_idx} !== 16'h0) begin
        errors++;
        $display("FAIL reset_idx cyc=%0d got=%h exp=0", c, {pre_addr, pre_sym, sym_idx});
      end
    end
  endtask

  task automatic test_basic_frame();
    exp_t e;
    exp_t o;
    int   rd_cnt;
    apply_reset();
    data_avail = 1'b1;
    rd_cnt     = 0;
    for (int c = 0; c < 70; c++) begin
      start = (c == 0);
      sb.push_back(frame_model(c, 0, 0));
      @(posedge clk);
      #1;
      if (data_rd === 1'b1) rd_cnt++;
      e = sb.pop_front();
      o = observe(e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL basic cyc=%0d got=%h exp=%h", c, o, e);
      end
    end
    checks++;
    if (rd_cnt != 32) begin
      errors++;
      $display("FAIL basic_rd_count got=%0d exp=32", rd_cnt);
    end
  endtask

  task automatic test_underflow();
    exp_t e;
    exp_t o;
    apply_reset();
    for (int c = 0; c < 76; c++) begin
      start      = (c == 0);
      data_avail = (c >= 25);
      sb.push_back(frame_model(c, 0, 5));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      o = observe(e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL underflow cyc=%0d got=%h exp=%h", c, o, e);
      end
    end
  endtask

  task automatic test_continuous();
    exp_t e;
    exp_t o;
    apply_reset();
    cont       = 1'b1;
    data_avail = 1'b1;
    for (int c = 0; c < 90; c++) begin
      start = (c == 0);
      sb.push_back(frame_model(c, 0, 0) | frame_model(c, 60, 0));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      o = observe(e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL continuous cyc=%0d got=%h exp=%h", c, o, e);
      end
    end
    cont = 1'b0;
  endtask

  task automatic test_mid_frame_reset();
    exp_t e;
    exp_t o;
    apply_reset();
    data_avail = 1'b1;
    for (int c = 0; c < 70; c++) begin
      start = (c == 0) || (c == 40);
      rst   = (c == 30);
      // The reset cycle itself is not constrained; everything after is.
      if (c != 30) begin
        if (c < 30)       sb.push_back(frame_model(c, 0, 0));
        else if (c <= 40) sb.push_back('0);
        else              sb.push_back(frame_model(c, 40, 0));
      end
      @(posedge clk);
      #1;
      if (c != 30) begin
        e = sb.pop_front();
        o = observe(e);
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL mid_reset cyc=%0d got=%h exp=%h", c, o, e);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_start_while_busy();
    exp_t e;
    exp_t o;
    apply_reset();
    data_avail = 1'b1;
    for (int c = 0; c < 70; c++) begin
      start = (c == 0) || (c == 10) || (c == 50);
      sb.push_back(frame_model(c, 0, 0));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      o = observe(e);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL start_busy cyc=%0d got=%h exp=%h", c, o, e);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    cont       = 1'b0;
    data_avail = 1'b0;
    test_reset();
    test_basic_frame();
    test_underflow();
    test_continuous();
    test_mid_frame_reset();
    test_start_while_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
